// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types for the NOR-latch sequencer.
// Grant encoding doubles as the arbiter pointer value.
package sr_latch_ctrl_pkg;

   typedef enum logic [2:0] {
      INIT_PULSE,
      INIT_SETTLE,
      IDLE,
      PULSE,
      SETTLE,
      CHECK,
      RESP
   } stateT;

   localparam logic GRANT_SET = 1'b0;
   localparam logic GRANT_CLR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// req[0]/gnt[0] is the set side, req[1]/gnt[1] the clear side.
module rr_arb2
   import sr_latch_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (ptr == GRANT_CLR) ? 2'b10 : 2'b01;
      end
   end

   // Pointer always moves to the requester that just lost out.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= GRANT_SET;
      end else if (advance && (gnt != 2'b00)) begin
         ptr <= ~gnt[1];
      end
   end

endmodule

// File: rtl/sr_latch_controller.sv
// Arbitrated set/clear sequencer for a cross-coupled NOR latch.
// Drives S/R pulses, waits to settle, samples and checks Q/Qn.
module sr_latch_controller
   import sr_latch_ctrl_pkg::*;
#(
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic set_valid,
   output logic set_ready,
   input  logic clr_valid,
   output logic clr_ready,
   output logic latch_s,
   output logic latch_r,
   input  logic latch_q,
   input  logic latch_qn,
   output logic resp_valid,
   output logic resp_grant,
   output logic resp_q,
   output logic resp_err,
   output logic busy
);

   localparam int MaxCycles =
      (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int CntW = $clog2(MaxCycles + 1);
   localparam logic [CntW-1:0] PulseLoad  = CntW'(PULSE_CYCLES - 1);
   localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne     = CntW'(1);

   if (PULSE_CYCLES < 1 || SETTLE_CYCLES < 1) begin : gParamCheck
      $error("PULSE_CYCLES and SETTLE_CYCLES must both be >= 1");
   end

   stateT state, nextState;
   logic [CntW-1:0] cnt, cntNext;
   logic [1:0] gnt;
   logic idle, advance, cntDone;
   logic grant, nextGrant, expQ;

   assign idle    = (state == IDLE);
   assign busy    = ~idle;
   assign cntDone = (cnt == '0);
   assign advance = idle && (gnt != 2'b00);
   assign expQ    = (grant == GRANT_SET);

   // Only the losing side of a simultaneous request sees ready low.
   assign set_ready = idle && !(set_valid && gnt[1]);
   assign clr_ready = idle && !(clr_valid && gnt[0]);

   rr_arb2 uArb (
      .clk     (clk),
      .rst     (rst),
      .req     ({clr_valid, set_valid}),
      .advance (advance),
      .gnt     (gnt)
   );

   always_comb begin
      nextState = state;
      cntNext   = cnt - CntOne;
      nextGrant = grant;
      unique case (state)
         INIT_PULSE: begin
            if (cntDone) begin
               nextState = INIT_SETTLE;
               cntNext   = SettleLoad;
            end
         end
         INIT_SETTLE: begin
            if (cntDone) begin
               nextState = IDLE;
               cntNext   = PulseLoad;
            end
         end
         IDLE: begin
            cntNext = PulseLoad;
            if (advance) begin
               nextState = PULSE;
               nextGrant = gnt[1] ? GRANT_CLR : GRANT_SET;
            end
         end
         PULSE: begin
            if (cntDone) begin
               nextState = SETTLE;
               cntNext   = SettleLoad;
            end
         end
         SETTLE: begin
            if (cntDone) begin
               nextState = CHECK;
               cntNext   = '0;
            end
         end
         CHECK: begin
            nextState = RESP;
            cntNext   = '0;
         end
         RESP: begin
            nextState = IDLE;
            cntNext   = PulseLoad;
         end
         default: begin
            nextState = INIT_PULSE;
            cntNext   = PulseLoad;
         end
      endcase
   end

   // Latch drives are registered from the next state so they never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INIT_PULSE;
         cnt        <= PulseLoad;
         grant      <= GRANT_SET;
         latch_s    <= 1'b0;
         latch_r    <= 1'b1;
         resp_valid <= 1'b0;
         resp_grant <= 1'b0;
         resp_q     <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         state      <= nextState;
         cnt        <= cntNext;
         grant      <= nextGrant;
         latch_s    <= (nextState == PULSE) && (nextGrant == GRANT_SET);
         latch_r    <= (nextState == INIT_PULSE) ||
                       ((nextState == PULSE) && (nextGrant == GRANT_CLR));
         resp_valid <= (nextState == RESP);
         if (state == CHECK) begin
            resp_grant <= grant;
            resp_q     <= latch_q;
            resp_err   <= (latch_q != expQ) || (latch_q == latch_qn);
         end
      end
   end

endmodule

// File: tb/tb_sr_latch_controller.sv
// Bench for sr_latch_controller with a behavioural NOR latch
// and a cycle-level reference model of the command timeline.
module tb_sr_latch_controller;

   localparam int P = 2;
   localparam int S = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic set_valid = 1'b0;
   logic clr_valid = 1'b0;
   logic latch_q, latch_qn;
   logic set_ready, clr_ready, latch_s, latch_r;
   logic resp_valid, resp_grant, resp_q, resp_err, busy;

   int errors = 0;
   int checks = 0;

   int cyc, freeAt, sFrom, sTo, rFrom, rTo, respAt;
   logic pref;
   logic pendG, pendQ, pendE;
   logic heldG, heldQ, heldE;
   logic reqS = 1'b0;
   logic reqC = 1'b0;
   int mode = 0;
   logic qState = 1'b0;

   sr_latch_controller #(
      .PULSE_CYCLES  (P),
      .SETTLE_CYCLES (S)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .set_valid  (set_valid),
      .set_ready  (set_ready),
      .clr_valid  (clr_valid),
      .clr_ready  (clr_ready),
      .latch_s    (latch_s),
      .latch_r    (latch_r),
      .latch_q    (latch_q),
      .latch_qn   (latch_qn),
      .resp_valid (resp_valid),
      .resp_grant (resp_grant),
      .resp_q     (resp_q),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // NOR latch: holds state unless exactly one input is high.
   always @(latch_s, latch_r) begin
      if (latch_s && !latch_r) qState = 1'b1;
      else if (latch_r && !latch_s) qState = 1'b0;
   end

   // mode 1: Q stuck at 0; mode 2: Q and Qn both 0.
   always_comb begin
      latch_q  = qState;
      latch_qn = ~qState;
      if (mode == 1) begin
         latch_q  = 1'b0;
         latch_qn = 1'b1;
      end else if (mode == 2) begin
         latch_q  = 1'b0;
         latch_qn = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic modelReset();
      cyc    = 0;
      freeAt = P + S;
      sFrom  = -100;
      sTo    = -100;
      rFrom  = 0;
      rTo    = P - 1;
      respAt = -100;
      pref   = 1'b0;
      heldG  = 1'b0;
      heldQ  = 1'b0;
      heldE  = 1'b0;
   endtask

   task automatic doReset(input int n);
      rst       = 1'b1;
      set_valid = 1'b0;
      clr_valid = 1'b0;
      reqS      = 1'b0;
      reqC      = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("rstLatchS", latch_s, 1'b0);
         chk("rstLatchR", latch_r, 1'b1);
         chk("rstSetRdy", set_ready, 1'b0);
         chk("rstClrRdy", clr_ready, 1'b0);
         chk("rstRespV", resp_valid, 1'b0);
         chk("rstRespQ", resp_q, 1'b0);
         chk("rstRespErr", resp_err, 1'b0);
         chk("rstBusy", busy, 1'b1);
      end
      rst = 1'b0;
      modelReset();
   endtask

   task automatic step();
      logic idle, both, g;
      set_valid = reqS;
      clr_valid = reqC;
      #1;
      idle = (cyc >= freeAt);
      both = reqS && reqC;
      if (cyc == respAt) begin
         heldG = pendG;
         heldQ = pendQ;
         heldE = pendE;
      end
      chk("setReady", set_ready, idle && (!both || pref == 1'b0));
      chk("clrReady", clr_ready, idle && (!both || pref == 1'b1));
      chk("busy", busy, !idle);
      chk("latchS", latch_s, (cyc >= sFrom) && (cyc <= sTo));
      chk("latchR", latch_r, (cyc >= rFrom) && (cyc <= rTo));
      chk("sAndR", latch_s && latch_r, 1'b0);
      chk("respValid", resp_valid, cyc == respAt);
      chk("respGrant", resp_grant, heldG);
      chk("respQ", resp_q, heldQ);
      chk("respErr", resp_err, heldE);
      if (idle && (reqS || reqC)) begin
         g      = both ? pref : reqC;
         pref   = ~g;
         respAt = cyc + P + S + 2;
         freeAt = cyc + P + S + 3;
         if (g) begin
            rFrom = cyc + 1;
            rTo   = cyc + P;
            reqC  = 1'b0;
         end else begin
            sFrom = cyc + 1;
            sTo   = cyc + P;
            reqS  = 1'b0;
         end
         pendG = g;
         if (mode == 1) begin
            pendQ = 1'b0;
            pendE = ~g;
         end else if (mode == 2) begin
            pendQ = 1'b0;
            pendE = 1'b1;
         end else begin
            pendQ = ~g;
            pendE = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic cycles(input int n);
      repeat (n) step();
   endtask

   initial begin
      modelReset();
      doReset(2);
      cycles(3);

      reqS = 1'b1;
      cycles(7);

      doReset(1);
      cycles(3);
      reqS = 1'b1;
      reqC = 1'b1;
      cycles(13);

      mode = 1;
      reqS = 1'b1;
      cycles(7);
      mode = 2;
      reqC = 1'b1;
      cycles(7);
      mode = 0;

      reqS = 1'b1;
      cycles(2);
      doReset(1);
      cycles(4);

      for (int i = 0; i < 30; i++) begin
         reqC = 1'b1;
         if (i >= 3) reqS = 1'b1;
         step();
      end
      reqS = 1'b0;
      reqC = 1'b0;
      cycles(7);

      for (int i = 0; i < 400; i++) begin
         if (!reqS) reqS = ($urandom_range(0, 3) == 0);
         if (!reqC) reqC = ($urandom_range(0, 3) == 0);
         if (cyc >= freeAt) begin
            mode = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sr_latch_controller.md
# sr_latch_controller

Sequencer and arbiter that owns the set/reset inputs of a generated cross-coupled NOR latch circuit and shares them between two requesters (set, clear). Guarantees the forbidden S=R=1 input is never driven, stretches each command to a fixed pulse width, waits a settle window, samples Q/Qn, and returns a checked response. Sits between the runner's stimulus logic and the latch circuit's input switches and output LEDs.

## Interface
- PULSE_CYCLES, 2, cycles S or R is held high per command (≥1)
- SETTLE_CYCLES, 1, idle cycles between pulse end and sampling (≥1)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- set_valid  in  1  set request
- set_ready  out  1  set request accepted when set_valid && set_ready
- clr_valid  in  1  clear request
- clr_ready  out  1  clear request accepted when clr_valid && clr_ready
- latch_s  out  1  registered drive to latch set input
- latch_r  out  1  registered drive to latch reset input
- latch_q  in  1  latch Q output
- latch_qn  in  1  latch Qn output
- resp_valid  out  1  one-cycle response strobe
- resp_grant  out  1  0 = set served, 1 = clear served
- resp_q  out  1  sampled latch_q
- resp_err  out  1  mismatch/illegal output detected
- busy  out  1  high in every state except IDLE

## Operation
- States: INIT_PULSE, INIT_SETTLE, IDLE, PULSE, SETTLE, CHECK, RESP.
- Reset values: state INIT_PULSE, latch_s 0, latch_r 1, set_ready/clr_ready 0, resp_valid/resp_grant/resp_q/resp_err 0, busy 1, RR pointer = set.
- INIT_PULSE: latch_r=1 for PULSE_CYCLES cycles → INIT_SETTLE (SETTLE_CYCLES cycles, S=R=0) → IDLE. Forces a known Q=0 after reset; no response generated.
- IDLE: set_ready/clr_ready high (combinational from state and arbiter). One valid → that one granted. Both valid → round-robin: pointer selects winner; pointer moves to the other requester after every grant. Only the winner's ready is high in a simultaneous cycle.
- PULSE: drive latch_s (set) or latch_r (clear) high for PULSE_CYCLES; the other held 0. latch_s && latch_r never both 1.
- SETTLE: both 0 for SETTLE_CYCLES.
- CHECK: register resp_q=latch_q; resp_err=1 if latch_q≠expected (1 for set, 0 for clear) or latch_q==latch_qn.
- RESP: resp_valid=1 for one cycle, no backpressure; → IDLE. resp_* fields hold until next CHECK.
- One down-counter, width $clog2(max(PULSE_CYCLES,SETTLE_CYCLES)+1), reloaded on each state entry.
- rst asserted in any state: same-edge return to reset values; in-flight command dropped, no response; INIT sequence reruns.

## Timing
- Init: first cycle with rst=0 is cycle 0; latch_r high cycles 0..P−1 (plus during reset), ready first high at cycle P+S.
- Grant at cycle T → latch_s/r high T+1..T+P, settle T+P+1..T+P+S, CHECK T+P+S+1, resp_valid T+P+S+2, ready high again T+P+S+3.
- Defaults (P=2,S=1): grant T, pulse T+1..T+2, resp_valid T+5, next grant earliest T+6.
- Requests arriving while busy wait (valid must be held; standard valid/ready).

## Structure
- Package sr_latch_ctrl_pkg: state enum, GRANT_SET=1'b0 / GRANT_CLR=1'b1 constants.
- Sub-module rr_arb2: two-requester round-robin arbiter (req[1:0], advance, gnt[1:0]), pointer flop inside, reset to set.
- Parameter checks: PULSE_CYCLES≥1, SETTLE_CYCLES≥1 via elaboration assertion.

## Test plan
- Reset release with latch model → latch_r high cycles 0–1, set_ready=clr_ready=1 at cycle 3, no resp_valid.
- Single set at T → latch_s high T+1..T+2, resp_valid at T+5 with grant=0, q=1, err=0.
- set_valid and clr_valid both high from T → set granted first (resp q=1), clear granted at T+6 (resp grant=1, q=0); both never high on latch_s/latch_r.
- Latch model forced stuck Q=0 on set → resp_err=1, resp_q=0; forced Q=Qn=0 on clear → resp_err=1.
- rst pulsed during PULSE → latch_s 0 and latch_r 1 next edge, no resp_valid, ready returns 3 cycles after rst release.
- Continuous clr_valid with set_valid asserted later → grants alternate clr/set once both pending; every response latency 5 cycles.
